// File: rtl/ql_dsp_z_collector_pkg.sv
// Shared types and constants for the DSP z-result collector.
package ql_dsp_pkg;

    localparam int unsigned NBITS_Z    = 38;
    localparam int unsigned ZCOL_DEPTH = 4;
    localparam int unsigned LAT_REG    = 2;
    localparam int unsigned LAT_NOREG  = 1;

    // One buffered DSP result.
    typedef struct packed {
        logic               frac;
        logic [NBITS_Z-1:0] data;
    } zcol_entry_t;

    // One slot of the in-flight tracking pipe.
    typedef struct packed {
        logic vld;
        logic frac;
    } zcol_trk_t;

    // DSP pipeline latency selected by the register_inputs configuration bit.
    function automatic int unsigned issue_latency(input logic register_inputs);
        return register_inputs ? LAT_REG : LAT_NOREG;
    endfunction

endpackage

// File: rtl/ql_dsp_z_collector_if.sv
// Result stream from the collector to the fabric.
// Optional QL_DSP_ZCOL_PARITY_EN adds the out_par_o member.
interface ql_dsp_z_collector_if;

    logic                              out_valid_o;
    logic                              out_ready_i;
    logic [ql_dsp_pkg::NBITS_Z-1:0]    out_data_o;
    logic                              out_frac_o;
`ifdef QL_DSP_ZCOL_PARITY_EN
    logic                              out_par_o;
`endif

`ifdef QL_DSP_ZCOL_PARITY_EN
    modport master (output out_valid_o, output out_data_o, output out_frac_o,
                    output out_par_o, input out_ready_i);
    modport slave  (input out_valid_o, input out_data_o, input out_frac_o,
                    input out_par_o, output out_ready_i);
`else
    modport master (output out_valid_o, output out_data_o, output out_frac_o,
                    input out_ready_i);
    modport slave  (input out_valid_o, input out_data_o, input out_frac_o,
                    output out_ready_i);
`endif

endinterface

// File: rtl/ql_dsp_z_collector_fifo.sv
// Generic synchronous FIFO with exact occupancy count and flush.
// Caller guarantees no push when full without a pop, and no pop when empty.
module ql_dsp_zcol_fifo #(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             valid,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             valid_q, valid_d;

    // Next-state: flush wins, otherwise independent push/pop with pointer wrap.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
        valid_d = (count_d != '0);
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign valid = valid_q;
    assign count = count_q;

endmodule

// File: rtl/ql_dsp_z_collector.sv
// Collects DSP z_o results after the tile's pipeline latency into a FIFO.
// Optional QL_DSP_ZCOL_PARITY_EN stores an even-parity bit per entry.
module ql_dsp_z_collector
    import ql_dsp_pkg::*;
#(
    parameter  int unsigned DEPTH = ZCOL_DEPTH,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clock_i,
    input  logic               reset_n_i,
    input  logic               flush_i,
    input  logic               register_inputs_i,
    input  logic               f_mode_i,
    input  logic               issue_i,
    output logic               issue_ready_o,
    input  logic [NBITS_Z-1:0] z_i,
    output logic [CNT_W-1:0]   count_o,
    output logic               err_o,
    ql_dsp_z_collector_if.master out_if
);

`ifdef QL_DSP_ZCOL_PARITY_EN
    localparam int unsigned PAR_W = 1;
`else
    localparam int unsigned PAR_W = 0;
`endif
    localparam int unsigned WORD_W = $bits(zcol_entry_t) + PAR_W;
    localparam int unsigned SUM_W  = CNT_W + 1;

    zcol_trk_t          stage0_q, stage0_d;
    zcol_trk_t          stage1_q, stage1_d;
    logic               err_q, err_d;
    logic               issue_ready_q, issue_ready_d;
    logic               lat2, pop, push, capture, room, collision;
    logic [CNT_W-1:0]   count, count_nx;
    logic [SUM_W-1:0]   credit_nx;
    zcol_entry_t        wentry;
    logic [WORD_W-1:0]  wword, rword;

    // Tracking pipe, capture/push decision, error and next-cycle credit.
    always_comb begin
        stage0_d  = '0;
        stage1_d  = stage0_q;
        err_d     = err_q;
        lat2      = (issue_latency(register_inputs_i) == LAT_REG);
        pop       = out_if.out_valid_o & out_if.out_ready_i & ~flush_i;
        room      = (count < CNT_W'(DEPTH)) | pop;
        capture   = stage1_q.vld & ~flush_i;
        push      = capture & room;
        collision = issue_i & ~lat2 & stage0_q.vld;
        if (flush_i) begin
            stage1_d = '0;
        end else begin
            if (issue_i) begin
                if (lat2) begin
                    stage0_d = '{vld: 1'b1, frac: f_mode_i};
                end else if (!stage0_q.vld) begin
                    stage1_d = '{vld: 1'b1, frac: f_mode_i};
                end
            end
            if ((issue_i & ~issue_ready_q) | collision | (capture & ~room)) begin
                err_d = 1'b1;
            end
        end
        count_nx      = flush_i ? '0 : (count + CNT_W'(push) - CNT_W'(pop));
        credit_nx     = SUM_W'(count_nx) + SUM_W'(stage0_d.vld) + SUM_W'(stage1_d.vld);
        issue_ready_d = (credit_nx < SUM_W'(DEPTH));
    end

    // State registers.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            stage0_q      <= '0;
            stage1_q      <= '0;
            err_q         <= 1'b0;
            issue_ready_q <= 1'b1;
        end else begin
            stage0_q      <= stage0_d;
            stage1_q      <= stage1_d;
            err_q         <= err_d;
            issue_ready_q <= issue_ready_d;
        end
    end

    assign wentry = '{frac: stage1_q.frac, data: z_i};
`ifdef QL_DSP_ZCOL_PARITY_EN
    assign wword = {^wentry, wentry};
    assign {out_if.out_par_o, out_if.out_frac_o, out_if.out_data_o} = rword;
`else
    assign wword = wentry;
    assign {out_if.out_frac_o, out_if.out_data_o} = rword;
`endif

    ql_dsp_zcol_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clock_i),
        .rst_n (reset_n_i),
        .flush (flush_i),
        .push  (push),
        .pop   (pop),
        .wdata (wword),
        .rdata (rword),
        .valid (out_if.out_valid_o),
        .count (count)
    );

    assign issue_ready_o = issue_ready_q;
    assign err_o         = err_q;
    assign count_o       = count;

endmodule

// File: tb/tb_ql_dsp_z_collector.sv
// Scoreboard bench for ql_dsp_z_collector; honours QL_DSP_ZCOL_PARITY_EN.
module tb_ql_dsp_z_collector;
    import ql_dsp_pkg::*;

    typedef struct packed {
        logic               v;
        logic               l2;
        logic [NBITS_Z-1:0] d;
    } hist_t;

    logic               clock = 1'b0;
    logic               reset_n = 1'b0;
    logic               flush = 1'b0;
    logic               reg_in = 1'b0;
    logic               f_mode = 1'b0;
    logic               issue = 1'b0;
    logic               issue_ready;
    logic [NBITS_Z-1:0] z = '0;
    logic [2:0]         count;
    logic               err;

    int                 n_checks = 0;
    int                 n_err = 0;
    zcol_entry_t        sb[$];
    hist_t              h1 = '0, h2 = '0, cur = '0;

    ql_dsp_z_collector_if zif ();

    ql_dsp_z_collector #(.DEPTH(4)) dut (
        .clock_i           (clock),
        .reset_n_i         (reset_n),
        .flush_i           (flush),
        .register_inputs_i (reg_in),
        .f_mode_i          (f_mode),
        .issue_i           (issue),
        .issue_ready_o     (issue_ready),
        .z_i               (z),
        .count_o           (count),
        .err_o             (err),
        .out_if            (zif)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus; a small DSP model delivers z after latency 1 or 2.
    task automatic tick(input bit iss, input bit l2, input bit frac,
                        input logic [NBITS_Z-1:0] v, input bit rdy, input bit fl, input bit exp);
        @(posedge clock);
        #1;
        h2 = h1;
        h1 = cur;
        if (h2.v && h2.l2)       z = h2.d;
        else if (h1.v && !h1.l2) z = h1.d;
        else                     z = '0;
        cur    = '{v: iss, l2: l2, d: v};
        issue  = iss;
        reg_in = l2;
        f_mode = frac;
        flush  = fl;
        zif.out_ready_i = rdy;
        if (exp) sb.push_back('{frac: frac, data: v});
    endtask

    task automatic idle(input bit rdy);
        tick(1'b0, 1'b0, 1'b0, '0, rdy, 1'b0, 1'b0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_count"},  64'(count), 64'(0));
        check({tag, "_valid"},  64'(zif.out_valid_o), 64'(0));
        check({tag, "_data"},   64'(zif.out_data_o), 64'(0));
        check({tag, "_frac"},   64'(zif.out_frac_o), 64'(0));
        check({tag, "_err"},    64'(err), 64'(0));
        check({tag, "_ready"},  64'(issue_ready), 64'(1));
`ifdef QL_DSP_ZCOL_PARITY_EN
        check({tag, "_par"},    64'(zif.out_par_o), 64'(0));
`endif
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        issue = 1'b0; flush = 1'b0; reg_in = 1'b0; f_mode = 1'b0; z = '0;
        zif.out_ready_i = 1'b0;
        h1 = '0; h2 = '0; cur = '0;
        sb.delete();
        repeat (2) @(posedge clock);
        #1;
        check_reset_vals("reset");
        #2 reset_n = 1'b1;
    endtask

    // Monitor: every accepted head is compared against the scoreboard.
    initial begin
        zcol_entry_t e;
        forever begin
            @(negedge clock);
            if (reset_n && !flush && zif.out_valid_o && zif.out_ready_i) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL pop_unexpected: got data %0h, expected no entry", zif.out_data_o);
                end else begin
                    e = sb.pop_front();
                    check("pop_data", 64'(zif.out_data_o), 64'(e.data));
                    check("pop_frac", 64'(zif.out_frac_o), 64'(e.frac));
`ifdef QL_DSP_ZCOL_PARITY_EN
                    check("pop_par",  64'(zif.out_par_o), 64'(^e));
`endif
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        zif.out_ready_i = 1'b0;
        do_reset();

        // 1: latency 1, no bypass into the output
        tick(1'b1, 1'b0, 1'b0, 38'h1234, 1'b1, 1'b0, 1'b1);
        idle(1'b1);
        check("s1_no_bypass", 64'(zif.out_valid_o), 64'(0));
        idle(1'b1);
        check("s1_valid", 64'(zif.out_valid_o), 64'(1));
        check("s1_count", 64'(count), 64'(1));
        idle(1'b1);
        check("s1_drained", 64'(count), 64'(0));

        // 4: steady stream with consumer always ready
        for (int i = 0; i < 16; i++) begin
            tick(1'b1, 1'b0, 1'(i % 2), 38'h100 + NBITS_Z'(i), 1'b1, 1'b0, 1'b1);
            check("s4_count_le2", 64'(count <= 3'd2), 64'(1));
            check("s4_ready", 64'(issue_ready), 64'(1));
        end
        repeat (4) idle(1'b1);
        check("s4_err", 64'(err), 64'(0));
        check("s4_count_end", 64'(count), 64'(0));

        // 2: latency 2, fractured, stalled consumer, credit exhaustion
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1'b1, 1'b1, 38'h2A_0000_0000 + NBITS_Z'(i), 1'b0, 1'b0, 1'b1);
            check("s2_ready_pre", 64'(issue_ready), 64'(1));
        end
        check("s2_err_pre", 64'(err), 64'(0));
        tick(1'b1, 1'b1, 1'b1, 38'h2A_0000_00FF, 1'b0, 1'b0, 1'b0);
        check("s2_ready_full", 64'(issue_ready), 64'(0));
        idle(1'b0);
        check("s2_err", 64'(err), 64'(1));
        idle(1'b0);
        check("s2_head_t6", 64'(zif.out_data_o), 64'(38'h2A_0000_0000));
        idle(1'b0);
        check("s2_count_full", 64'(count), 64'(4));
        check("s2_head_t7", 64'(zif.out_data_o), 64'(38'h2A_0000_0000));
        check("s2_ready_t7", 64'(issue_ready), 64'(0));
        // push and pop in the same cycle while full
        tick(1'b1, 1'b0, 1'b0, 38'h0B_0000_0001, 1'b0, 1'b0, 1'b1);
        idle(1'b1);
        idle(1'b0);
        check("s2_full_pushpop", 64'(count), 64'(4));
        repeat (8) idle(1'b1);
        check("s2_drained", 64'(count), 64'(0));
        do_reset();

        // 3: collision, latency-2 issue wins
        tick(1'b1, 1'b1, 1'b0, 38'h0C_CCCC_CCCC, 1'b0, 1'b0, 1'b1);
        check("s3_err_pre", 64'(err), 64'(0));
        tick(1'b1, 1'b0, 1'b1, 38'h0D_DDDD_DDDD, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        check("s3_count_t2", 64'(count), 64'(0));
        idle(1'b0);
        check("s3_count_t3", 64'(count), 64'(1));
        check("s3_err", 64'(err), 64'(1));
        repeat (2) idle(1'b0);
        check("s3_single_push", 64'(count), 64'(1));
        repeat (3) idle(1'b1);
        check("s3_drained", 64'(count), 64'(0));
        do_reset();

        // 5: flush with three buffered and two in flight
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 1'b1, 1'b0, 38'h0E_0000_0000 + NBITS_Z'(i), 1'b0, 1'b0, 1'b0);
        end
        tick(1'b1, 1'b0, 1'b0, 38'h0E_0000_00FF, 1'b0, 1'b1, 1'b0);
        check("s5_count_pre", 64'(count), 64'(3));
        check("s5_ready_pre", 64'(issue_ready), 64'(0));
        idle(1'b0);
        check("s5_count_flush", 64'(count), 64'(0));
        check("s5_valid_flush", 64'(zif.out_valid_o), 64'(0));
        check("s5_ready_flush", 64'(issue_ready), 64'(1));
        check("s5_err_sticky", 64'(err), 64'(1));
        for (int i = 0; i < 4; i++) begin
            idle(1'b0);
            check("s5_no_late_push", 64'(count), 64'(0));
            check("s5_no_late_valid", 64'(zif.out_valid_o), 64'(0));
        end

        // 6: asynchronous reset mid-stream
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b0, 1'b1, 38'h0F_0000_0000 + NBITS_Z'(i), 1'b0, 1'b0, 1'b0);
        end
        check("s6_count_pre", 64'(count), 64'(1));
        check("s6_err_pre", 64'(err), 64'(1));
        #2 reset_n = 1'b0;
        #1;
        check_reset_vals("s6_async");
        do_reset();

        for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clock);
        check("sb_empty", 64'(sb.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
